background_sequencer: RTL



---
 rtl/background_sequencer_pkg.sv | 29 ++
 rtl/background_sequencer_bg_request_latch.sv | 111 +++++++++++
 rtl/background_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/background_sequencer_pkg.sv
// Shared definitions for the background sequencer: set codes, geometry
// defaults, tile address width and FSM state encodings.
// Optional feature macro: BG_AUTO_CYCLE_EN (automatic set advance every
// DEF_AUTO_FRAMES frames).
package background_sequencer_pkg;

   localparam logic [1:0] BG_SET1 = 2'b00;
   localparam logic [1:0] BG_SET2 = 2'b01;
   localparam logic [1:0] BG_SET3 = 2'b10;
   localparam logic [1:0] BG_SET4 = 2'b11;

   localparam int TILE_ADDR_W     = 13;
   localparam int DEF_H_TILES     = 120;
   localparam int DEF_V_TILES     = 68;
   localparam int DEF_TILE_W      = 4;
   localparam int DEF_TILE_H      = 4;
   localparam int DEF_AUTO_FRAMES = 600;

   localparam logic [1:0] WAIT_FRAME    = 2'd0;
   localparam logic [1:0] LINE_WAIT     = 2'd1;
   localparam logic [1:0] ACTIVE        = 2'd2;
   localparam logic [1:0] OUT_OF_REGION = 2'd3;

   // Sets form a ring of four; advancing past the last one returns to the first.
   function automatic logic [1:0] next_set(input logic [1:0] cur);
      return cur + 2'd1;
   endfunction

endpackage

// File: rtl/background_sequencer_bg_request_latch.sv
// Background-set request latch. Holds one pending set change and applies it
// on the frame-start edge so the generator never switches sets mid-frame.
// Optional feature macro: BG_AUTO_CYCLE_EN adds a frame counter that issues
// an internal next-set request every AUTO_FRAMES frames.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   frame_start   first cycle of a frame; applies the pending set
//   bg_next       request advance to the next set
//   bg_load       request load of bg_sel (wins over bg_next)
//   bg_sel        set value for bg_load
//   bg_set        set currently driven to the generator
//   busy          a set change is pending
module bg_request_latch
   import background_sequencer_pkg::*;
`ifdef BG_AUTO_CYCLE_EN
#(
   parameter int AUTO_FRAMES = DEF_AUTO_FRAMES
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       bg_next,
   input  logic       bg_load,
   input  logic [1:0] bg_sel,
   output logic [1:0] bg_set,
   output logic       busy
);

   logic       pend_valid;
   logic [1:0] pend_val;
   logic       pend_auto;
   logic       take_auto;
   logic       req;
   logic [1:0] applied;
   logic [1:0] next_base;
   logic [1:0] req_val;

   assign applied = pend_valid ? pend_val : bg_set;

   // A next-request builds on the pending value, except when that pending
   // value was produced by the auto-advance: external requests override it.
   // On a frame-start edge the request is deferred and builds on the set
   // that is being applied on that same edge.
   assign next_base = (frame_start || !pend_auto) ? applied : bg_set;
   assign req       = bg_next | bg_load | take_auto;
   assign req_val   = bg_load ? bg_sel : next_set(next_base);
   assign busy      = pend_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bg_set     <= BG_SET1;
         pend_valid <= 1'b0;
         pend_val   <= BG_SET1;
      end else begin
         if (frame_start)
            bg_set <= applied;
         if (req) begin
            pend_valid <= 1'b1;
            pend_val   <= req_val;
         end else if (frame_start) begin
            pend_valid <= 1'b0;
         end
      end
   end

`ifdef BG_AUTO_CYCLE_EN
   localparam int CNT_W = $clog2(AUTO_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

   logic [CNT_W-1:0] frame_cnt;
   logic             auto_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         auto_req  <= 1'b0;
      end else begin
         auto_req <= 1'b0;
         if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
               frame_cnt <= '0;
               auto_req  <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
         if (bg_load)
            frame_cnt <= '0;
      end
   end

   // The auto request fires the cycle after frame start; it yields to any
   // external request in that cycle or one deferred into this frame.
   assign take_auto = auto_req && !bg_next && !bg_load && !pend_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pend_auto <= 1'b0;
      else if (req)
         pend_auto <= take_auto;
      else if (frame_start)
         pend_auto <= 1'b0;
   end
`else
   assign take_auto = 1'b0;
   assign pend_auto = 1'b0;
`endif

endmodule

// File: rtl/background_sequencer.sv
// Scan-side controller for the tiled background generator. Turns raster
// strobes into the tile address stream, a pixel-valid flag aligned with the
// generator's registered output, and a frame-synchronous set select.
// Optional feature macro: BG_AUTO_CYCLE_EN (auto set advance, AUTO_FRAMES).
// Ports:
//   i_clk, i_rst_n   pixel clock, asynchronous active-low reset
//   i_frame_start    first cycle of a frame
//   i_line_start     cycle before the first active pixel of a line
//   i_pix_en         active pixel
//   i_bg_next        request next set
//   i_bg_load        request load of i_bg_sel
//   i_bg_sel         set value for i_bg_load
//   o_address        tile address for the current pixel (combinational)
//   o_bg_set         set select
//   o_pix_valid      generator data valid (i_pix_en delayed one cycle)
//   o_busy           set change pending
//
// state         | meaning
// WAIT_FRAME    | after reset; line/pixel strobes ignored until frame start
// LINE_WAIT     | between lines, waiting for i_line_start
// ACTIVE        | counting pixels of the current line
// OUT_OF_REGION | all tile rows done; address 0, no valid pixels
module background_sequencer
   import background_sequencer_pkg::*;
#(
   parameter int H_TILES = DEF_H_TILES,
   parameter int V_TILES = DEF_V_TILES,
   parameter int TILE_W  = DEF_TILE_W,
   parameter int TILE_H  = DEF_TILE_H
`ifdef BG_AUTO_CYCLE_EN
   ,
   parameter int AUTO_FRAMES = DEF_AUTO_FRAMES
`endif
)
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_frame_start,
   input  logic                   i_line_start,
   input  logic                   i_pix_en,
   input  logic                   i_bg_next,
   input  logic                   i_bg_load,
   input  logic [1:0]             i_bg_sel,
   output logic [TILE_ADDR_W-1:0] o_address,
   output logic [1:0]             o_bg_set,
   output logic                   o_pix_valid,
   output logic                   o_busy
);

   localparam int ADDR_W = TILE_ADDR_W;
   localparam int COL_W  = $clog2(H_TILES + 1);
   localparam int LINE_W = $clog2(V_TILES * TILE_H + 1);
   localparam int PX_W   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int LS_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;

   // col saturates at H_TILES, which marks pixels beyond the last tile.
   localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_TILES);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_TILES * TILE_H - 1);
   localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(TILE_W - 1);
   localparam logic [LS_W-1:0]   LS_LAST   = LS_W'(TILE_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_TILES);
   localparam logic [ADDR_W-1:0] COL_SAT   = ADDR_W'(H_TILES - 1);

   logic [1:0]        state;
   logic [PX_W-1:0]   px_sub;
   logic [COL_W-1:0]  col;
   logic [LS_W-1:0]   line_sub;
   logic [LINE_W-1:0] line_cnt;
   logic [ADDR_W-1:0] row_base;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= WAIT_FRAME;
         px_sub   <= '0;
         col      <= '0;
         line_sub <= '0;
         line_cnt <= '0;
         row_base <= '0;
      end else if (i_frame_start) begin
         state    <= LINE_WAIT;
         px_sub   <= '0;
         col      <= '0;
         line_sub <= '0;
         line_cnt <= '0;
         row_base <= '0;
      end else begin
         case (state)
            LINE_WAIT: begin
               if (i_line_start) begin
                  state  <= ACTIVE;
                  px_sub <= '0;
                  col    <= '0;
               end
            end
            ACTIVE: begin
               if (i_pix_en) begin
                  if (px_sub == PX_LAST) begin
                     px_sub <= '0;
                     if (col != COL_END)
                        col <= col + 1'b1;
                  end else begin
                     px_sub <= px_sub + 1'b1;
                  end
               end else begin
                  // End of line: step the vertical counters.
                  line_cnt <= line_cnt + 1'b1;
                  if (line_sub == LS_LAST) begin
                     line_sub <= '0;
                     row_base <= row_base + ROW_STEP;
                  end else begin
                     line_sub <= line_sub + 1'b1;
                  end
                  state <= (line_cnt == LINE_LAST) ? OUT_OF_REGION : LINE_WAIT;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_address = '0;
      if (state == ACTIVE)
         o_address = (col == COL_END) ? (row_base + COL_SAT) : (row_base + ADDR_W'(col));
   end

   // Registered so it lines up with the generator's one-cycle data latency.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_pix_valid <= 1'b0;
      else
         o_pix_valid <= (state == ACTIVE) && i_pix_en && (col != COL_END);
   end

   bg_request_latch
`ifdef BG_AUTO_CYCLE_EN
      #(.AUTO_FRAMES(AUTO_FRAMES))
`endif
      u_req (
         .clk         (i_clk),
         .rst_n       (i_rst_n),
         .frame_start (i_frame_start),
         .bg_next     (i_bg_next),
         .bg_load     (i_bg_load),
         .bg_sel      (i_bg_sel),
         .bg_set      (o_bg_set),
         .busy        (o_busy)
      );

endmodule
